// File: rtl/fab_osc_clkdiv_mc.sv
// Multi-channel clock divider running on a free fabric oscillator.
// Each channel produces a one-cycle clock-enable strobe per divided period and a
// registered square wave. New ratios are staged in a pending register and only
// take effect at a period boundary (or at once while the channel is idle).
// Optional feature: define FAB_OSC_CLKDIV_PHASE_ALIGN_EN to let SYNC restart all
// enabled channels in phase; otherwise SYNC is ignored.
module fab_osc_clkdiv_mc #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned DIV_RST = 2
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [NUM_CH-1:0]       CH_EN,
   input  logic [NUM_CH*CNT_W-1:0] DIV_VAL,
   input  logic [NUM_CH-1:0]       DIV_LOAD,
   input  logic                    SYNC,
   output logic [NUM_CH-1:0]       DIV_ACK,
   output logic [NUM_CH-1:0]       CE_OUT,
   output logic [NUM_CH-1:0]       DIV_CLK_OUT
);

   localparam logic [CNT_W-1:0] RstRatio = CNT_W'(DIV_RST);
   localparam logic [CNT_W-1:0] One      = CNT_W'(1);

   logic [CNT_W-1:0]  cnt_q      [NUM_CH];
   logic [CNT_W-1:0]  cnt_d      [NUM_CH];
   logic [CNT_W-1:0]  ratio_q    [NUM_CH];
   logic [CNT_W-1:0]  ratio_d    [NUM_CH];
   logic [CNT_W-1:0]  pend_val_q [NUM_CH];
   logic [CNT_W-1:0]  pend_val_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] ce_q, ce_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic [NUM_CH-1:0] dclk_q, dclk_d;
   logic              sync_en;

`ifdef FAB_OSC_CLKDIV_PHASE_ALIGN_EN
   assign sync_en = SYNC;
`else
   logic unused_sync;
   assign unused_sync = SYNC;
   assign sync_en     = 1'b0;
`endif

   // Per-channel next state: count/wrap, pending-ratio apply, load capture, outputs.
   always_comb begin
      logic apply;
      apply = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]      = cnt_q[i];
         ratio_d[i]    = ratio_q[i];
         pend_val_d[i] = pend_val_q[i];
         pend_d[i]     = pend_q[i];
         ce_d[i]       = 1'b0;
         ack_d[i]      = 1'b0;
         dclk_d[i]     = 1'b0;
         apply         = 1'b0;

         if (!CH_EN[i] || sync_en) begin
            // Idle or phase-aligned: counter restarts, no strobe, pending ratio may land.
            cnt_d[i] = '0;
            apply    = pend_q[i];
         end else if ((ratio_q[i] <= One) || (cnt_q[i] >= ratio_q[i] - One)) begin
            // Period boundary; ratios 0 and 1 wrap on every edge.
            cnt_d[i] = '0;
            ce_d[i]  = 1'b1;
            apply    = pend_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + One;
         end

         // The older pending value is applied before a coincident load overwrites it.
         if (apply) begin
            ratio_d[i] = pend_val_q[i];
            ack_d[i]   = 1'b1;
            pend_d[i]  = 1'b0;
         end
         if (DIV_LOAD[i]) begin
            pend_val_d[i] = DIV_VAL[i*CNT_W +: CNT_W];
            pend_d[i]     = 1'b1;
         end

         // High for the first floor(R/2) counts; never high for R <= 1.
         dclk_d[i] = CH_EN[i] && (cnt_d[i] < (ratio_d[i] >> 1));
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]      <= '0;
            ratio_q[i]    <= RstRatio;
            pend_val_q[i] <= '0;
         end
         pend_q <= '0;
         ce_q   <= '0;
         ack_q  <= '0;
         dclk_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]      <= cnt_d[i];
            ratio_q[i]    <= ratio_d[i];
            pend_val_q[i] <= pend_val_d[i];
         end
         pend_q <= pend_d;
         ce_q   <= ce_d;
         ack_q  <= ack_d;
         dclk_q <= dclk_d;
      end
   end

   assign CE_OUT      = ce_q;
   assign DIV_ACK     = ack_q;
   assign DIV_CLK_OUT = dclk_q;

endmodule

// File: tb/tb_fab_osc_clkdiv_mc.sv
// Self-checking bench for fab_osc_clkdiv_mc: directed table, corner sequences and
// randomized traffic compared against a period-based reference model.
module tb_fab_osc_clkdiv_mc;

   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam int RST_R = 2;

   logic              clk, rst, sync;
   logic [NCH-1:0]    ch_en, div_load, div_ack, ce_out, div_clk_out;
   logic [NCH*CW-1:0] div_val;

   int errs = 0;
   int checks = 0;

   fab_osc_clkdiv_mc #(
      .NUM_CH (NCH),
      .CNT_W  (CW),
      .DIV_RST(RST_R)
   ) dut (
      .CLK        (clk),
      .RESET      (rst),
      .CH_EN      (ch_en),
      .DIV_VAL    (div_val),
      .DIV_LOAD   (div_load),
      .SYNC       (sync),
      .DIV_ACK    (div_ack),
      .CE_OUT     (ce_out),
      .DIV_CLK_OUT(div_clk_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: position within the current divided period per channel.
   int             m_ratio [NCH];
   int             m_pos   [NCH];
   int             m_pval  [NCH];
   bit             m_pend  [NCH];
   logic [NCH-1:0] e_ce, e_ack, e_dclk;

   // Per-scenario history of outputs, bit n = value after edge n.
   logic [63:0] ce_hist [NCH];
   logic [63:0] ack_hist[NCH];
   logic [63:0] dclk_hist[NCH];
   int          edge_n;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_ratio[i] = RST_R;
         m_pos[i]   = 0;
         m_pval[i]  = 0;
         m_pend[i]  = 0;
      end
      e_ce = '0; e_ack = '0; e_dclk = '0;
   endfunction

   function automatic void model_step();
      int eff;
      bit fire, sync_on;
`ifdef FAB_OSC_CLKDIV_PHASE_ALIGN_EN
      sync_on = sync;
`else
      sync_on = 1'b0;
`endif
      for (int i = 0; i < NCH; i++) begin
         eff  = (m_ratio[i] < 2) ? 1 : m_ratio[i];
         fire = 0;
         e_ce[i] = 1'b0;
         e_ack[i] = 1'b0;
         if (!ch_en[i] || sync_on) begin
            m_pos[i] = 0;
            fire = m_pend[i];
         end else begin
            m_pos[i]++;
            if (m_pos[i] == eff) begin
               m_pos[i] = 0;
               e_ce[i]  = 1'b1;
               fire     = m_pend[i];
            end
         end
         if (fire) begin
            m_ratio[i] = m_pval[i];
            m_pend[i]  = 0;
            e_ack[i]   = 1'b1;
         end
         if (div_load[i]) begin
            m_pval[i] = int'(div_val[i*CW +: CW]);
            m_pend[i] = 1;
         end
         e_dclk[i] = ch_en[i] && (m_pos[i] < m_ratio[i] / 2);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      if (!rst) model_step();
      #1;
      check("ce_out", ce_out, e_ce);
      check("div_ack", div_ack, e_ack);
      check("div_clk_out", div_clk_out, e_dclk);
      if (edge_n < 64) begin
         for (int i = 0; i < NCH; i++) begin
            ce_hist[i][edge_n]   = ce_out[i];
            ack_hist[i][edge_n]  = div_ack[i];
            dclk_hist[i][edge_n] = div_clk_out[i];
         end
      end
      edge_n++;
   endtask

   task automatic start_log();
      edge_n = 1;
      for (int i = 0; i < NCH; i++) begin
         ce_hist[i] = '0; ack_hist[i] = '0; dclk_hist[i] = '0;
      end
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock.
   task automatic do_reset();
      ch_en = '0; div_load = '0; sync = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_ce", ce_out, 0);
      check("rst_ack", div_ack, 0);
      check("rst_dclk", div_clk_out, 0);
      model_reset();
      #1 rst = 1'b0;
   endtask

   // Load a ratio into the given channel mask while those channels are idle.
   task automatic load_idle(logic [NCH-1:0] mask, logic [NCH*CW-1:0] vals);
      div_val = vals; div_load = mask;
      step();
      div_load = '0;
      step();
   endtask

   typedef struct {
      logic [NCH-1:0] en;
      logic [NCH-1:0] ce;
      logic [NCH-1:0] dclk;
   } vec_t;

   vec_t tbl[7];

   initial begin
      // Divide-by-2 from reset, then a second channel joins.
      tbl[0] = '{en: 4'b0001, ce: 4'b0000, dclk: 4'b0000};
      tbl[1] = '{en: 4'b0001, ce: 4'b0001, dclk: 4'b0001};
      tbl[2] = '{en: 4'b0001, ce: 4'b0000, dclk: 4'b0000};
      tbl[3] = '{en: 4'b0001, ce: 4'b0001, dclk: 4'b0001};
      tbl[4] = '{en: 4'b0011, ce: 4'b0000, dclk: 4'b0000};
      tbl[5] = '{en: 4'b0011, ce: 4'b0011, dclk: 4'b0011};
      tbl[6] = '{en: 4'b0000, ce: 4'b0000, dclk: 4'b0000};

      rst = 1'b1; ch_en = '0; div_load = '0; div_val = '0; sync = 1'b0;
      model_reset();
      start_log();
      #12;
      do_reset();

      start_log();
      for (int r = 0; r < 7; r++) begin
         ch_en = tbl[r].en;
         step();
         check("tbl_ce", ce_out, tbl[r].ce);
         check("tbl_dclk", div_clk_out, tbl[r].dclk);
         check("tbl_ack", div_ack, 0);
      end

      // Load 5 at count 1 of ratio 4: period 4 holds until the wrap.
      do_reset();
      load_idle(4'b0001, 64'd4);
      start_log();
      ch_en = 4'b0001;
      step();
      div_val = 64'd5; div_load = 4'b0001;
      step();
      div_load = '0;
      repeat (12) step();
      check("r4to5_ce", ce_hist[0], (64'd1 << 4) | (64'd1 << 9) | (64'd1 << 14));
      check("r4to5_ack", ack_hist[0], 64'd1 << 4);
      check("r4to5_dclk", dclk_hist[0], (64'd1 << 1) | (64'd1 << 4) | (64'd1 << 5) |
            (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 14));

      // Two loads before the wrap: only the last one lands, one ACK.
      do_reset();
      load_idle(4'b0001, 64'd8);
      start_log();
      ch_en = 4'b0001;
      step();
      div_val = 64'd6; div_load = 4'b0001;
      step();
      div_load = '0;
      step();
      div_val = 64'd9; div_load = 4'b0001;
      step();
      div_load = '0;
      repeat (16) step();
      check("lastload_ce", ce_hist[0], (64'd1 << 8) | (64'd1 << 17));
      check("lastload_ack", ack_hist[0], 64'd1 << 8);

      // Load coincident with an apply edge: two ACKs on consecutive wraps.
      do_reset();
      start_log();
      ch_en = 4'b0001;
      div_val = 64'd3; div_load = 4'b0001;
      step();
      div_val = 64'd5;
      step();
      div_load = '0;
      repeat (10) step();
      check("coinc_ce", ce_hist[0], (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 10));
      check("coinc_ack", ack_hist[0], (64'd1 << 2) | (64'd1 << 5));

      // Ratios 0 and 1 behave as divide-by-1.
      do_reset();
      load_idle(4'b0011, {16'd0, 16'd0, 16'd1, 16'd0});
      start_log();
      ch_en = 4'b0011;
      repeat (5) step();
      check("r0_ce", ce_hist[0], 64'h3E);
      check("r1_ce", ce_hist[1], 64'h3E);
      check("r0_dclk", dclk_hist[0], 64'h0);
      check("r1_dclk", dclk_hist[1], 64'h0);

      // Enable dropped at count 2 of ratio 8: no strobe, counter restarts.
      do_reset();
      load_idle(4'b0100, {16'd0, 16'd8, 16'd0, 16'd0});
      start_log();
      ch_en = 4'b0100;
      repeat (2) step();
      ch_en = 4'b0000;
      step();
      ch_en = 4'b0100;
      repeat (8) step();
      check("endrop_ce", ce_hist[2], 64'd1 << 11);

      // Reset with a pending load: no ACK, ratio back to the reset value.
      do_reset();
      ch_en = 4'b0001;
      step();
      div_val = 64'd7; div_load = 4'b0001;
      step();
      div_load = '0;
      check("prerst_ce", ce_out, 4'b0001);
      do_reset();
      start_log();
      ch_en = 4'b0001;
      repeat (6) step();
      check("postrst_ce", ce_hist[0], (64'd1 << 2) | (64'd1 << 4) | (64'd1 << 6));
      check("postrst_ack", ack_hist[0], 64'h0);

      // SYNC with channels at ratios 3 and 4 out of phase.
      do_reset();
      load_idle(4'b0011, {16'd0, 16'd0, 16'd4, 16'd3});
      start_log();
      ch_en = 4'b0011;
      repeat (5) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      repeat (6) step();
`ifdef FAB_OSC_CLKDIV_PHASE_ALIGN_EN
      check("sync_ce0", ce_hist[0], (64'd1 << 3) | (64'd1 << 9) | (64'd1 << 12));
      check("sync_ce1", ce_hist[1], (64'd1 << 4) | (64'd1 << 10));
`else
      check("sync_ce0", ce_hist[0], (64'd1 << 3) | (64'd1 << 6) | (64'd1 << 9) | (64'd1 << 12));
      check("sync_ce1", ce_hist[1], (64'd1 << 4) | (64'd1 << 8) | (64'd1 << 12));
`endif

      // Randomized traffic against the model.
      do_reset();
      ch_en = 4'hF;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
         for (int i = 0; i < NCH; i++) begin
            div_val[i*CW +: CW] = CW'($urandom_range(0, 9));
            div_load[i] = ($urandom_range(0, 7) == 0);
         end
         sync = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
            ch_en = 4'hF;
         end
         step();
      end
      div_load = '0; sync = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
